// File: rtl/ppu_pkg.sv
// Shared PPU definitions: register indices, palette page,
// port state encoding and the palette mirror helper.
package ppu_pkg;

  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_ADDR   = 3'd6;
  localparam logic [2:0] REG_DATA   = 3'd7;

  localparam logic [5:0] PAL_PAGE = 6'h3F;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WRITE
  } port_state_t;

  // 14/18/1C fold onto 04/08/0C; 10 is left for the
  // palette RAM, which aliases 00/10 on its own.
  function automatic logic [4:0] pal_mirror(
    input logic [4:0] idx
  );
    if (idx[4] && idx[1:0] == 2'b00 && idx[3:2] != 2'b00)
      pal_mirror = {1'b0, idx[3:0]};
    else
      pal_mirror = idx;
  endfunction

endpackage

// File: rtl/ppu_vram_port.sv
// CPU data port of the PPU: PPUADDR/PPUDATA/PPUSTATUS decode,
// v/t/w, read buffer, VRAM strobes and palette port mux.
module ppu_vram_port
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [2:0]  cpu_reg,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        vram_inc32,
  input  logic        render_active,
  input  logic [4:0]  render_pal_idx,
  output logic        busy,
  output logic [13:0] vram_addr,
  output logic [7:0]  vram_wdata,
  output logic        vram_we,
  output logic        vram_re,
  input  logic [7:0]  vram_rdata,
  output logic [4:0]  pal_addr,
  output logic [7:0]  pal_data_in,
  output logic        pal_we,
  input  logic [7:0]  pal_data_out
);

  port_state_t state, state_nx;

  logic [13:0] v, t, fetch_addr, v_inc;
  logic        w;
  logic [7:0]  rd_buf;
  logic [4:0]  pal_wr_addr;
  logic        in_pal, acc_data, wr_addr, rd_stat;

  assign in_pal   = v[13:8] == PAL_PAGE;
  assign acc_data = cpu_cs && cpu_reg == REG_DATA
                 && state == IDLE;
  assign wr_addr  = cpu_cs && cpu_reg == REG_ADDR && !cpu_rw;
  assign rd_stat  = cpu_cs && cpu_reg == REG_STATUS && cpu_rw;
  assign v_inc    = v + (vram_inc32 ? 14'd32 : 14'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (acc_data && cpu_rw)       state_nx = FETCH;
        else if (acc_data && !in_pal) state_nx = WRITE;
      end
      FETCH:   state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = state != IDLE;
    vram_re   = state == FETCH;
    vram_we   = state == WRITE;
    vram_addr = (state == IDLE) ? v : fetch_addr;
  end

  // A palette write lands one cycle late, after v has moved,
  // so the strobe cycle uses the address latched with it.
  always_comb begin
    if (render_active) pal_addr = render_pal_idx;
    else if (pal_we)   pal_addr = pal_wr_addr;
    else               pal_addr = pal_mirror(v[4:0]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v           <= '0;
      t           <= '0;
      w           <= 1'b0;
      rd_buf      <= '0;
      cpu_dout    <= '0;
      vram_wdata  <= '0;
      fetch_addr  <= '0;
      pal_we      <= 1'b0;
      pal_data_in <= '0;
      pal_wr_addr <= '0;
    end else begin
      pal_we <= 1'b0;
      if (rd_stat) w <= 1'b0;
      if (wr_addr) begin
        if (!w) begin
          t[13:8] <= cpu_din[5:0];
          w       <= 1'b1;
        end else begin
          t[7:0] <= cpu_din;
          v      <= {t[13:8], cpu_din};
          w      <= 1'b0;
        end
      end
      if (acc_data) begin
        v <= v_inc;
        unique case (1'b1)
          cpu_rw && in_pal: begin
            cpu_dout   <= pal_data_out;
            fetch_addr <= v & 14'h2FFF;
          end
          cpu_rw && !in_pal: begin
            cpu_dout   <= rd_buf;
            fetch_addr <= v;
          end
          !cpu_rw && in_pal: begin
            pal_we      <= !render_active;
            pal_data_in <= cpu_din;
            pal_wr_addr <= pal_mirror(v[4:0]);
          end
          default: begin
            vram_wdata <= cpu_din;
            fetch_addr <= v;
          end
        endcase
      end
      if (state == CAPTURE) rd_buf <= vram_rdata;
    end
  end

endmodule

// File: tb/tb_ppu_vram_port.sv
// Self-checking bench for ppu_vram_port: directed cases plus
// random register traffic against a transaction-level model.
module tb_ppu_vram_port;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_cs, cpu_rw;
  logic [2:0]  cpu_reg;
  logic [7:0]  cpu_din, cpu_dout;
  logic        vram_inc32, render_active;
  logic [4:0]  render_pal_idx;
  logic        busy;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we, vram_re;
  logic [7:0]  vram_rdata = 8'h00;
  logic [4:0]  pal_addr;
  logic [7:0]  pal_data_in;
  logic        pal_we;
  logic [7:0]  pal_data_out;

  ppu_vram_port dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_cs(cpu_cs), .cpu_rw(cpu_rw), .cpu_reg(cpu_reg),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .vram_inc32(vram_inc32), .render_active(render_active),
    .render_pal_idx(render_pal_idx), .busy(busy),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .vram_we(vram_we), .vram_re(vram_re),
    .vram_rdata(vram_rdata), .pal_addr(pal_addr),
    .pal_data_in(pal_data_in), .pal_we(pal_we),
    .pal_data_out(pal_data_out)
  );

  always #5 clk = ~clk;

  // Memories attached to the DUT.
  logic [7:0] vram_mem [0:16383];
  logic [7:0] pal_mem  [0:31];

  // The palette RAM only aliases 10 onto 00.
  function automatic int mem_fold(input logic [4:0] a);
    return (a == 5'h10) ? 0 : int'(a);
  endfunction

  always @(posedge clk) begin
    if (vram_we) vram_mem[vram_addr] <= vram_wdata;
    if (vram_re) vram_rdata <= vram_mem[vram_addr];
  end

  always @(negedge clk)
    if (pal_we) pal_mem[mem_fold(pal_addr)] <= pal_data_in;

  assign pal_data_out = pal_mem[mem_fold(pal_addr)];

  // Reference model state.
  logic [7:0] ref_vram [0:16383];
  logic [7:0] ref_pal  [0:31];
  logic [13:0] m_v, m_t;
  logic        m_w;
  logic [7:0]  m_buf, m_dout;
  int          m_busy;
  logic        m_palwr;

  int n_chk = 0;
  int n_err = 0;

  // Visible palette entry for a 5-bit index: every multiple
  // of 4 in the upper half aliases the lower half.
  function automatic int ref_idx(input logic [4:0] a);
    int x;
    x = int'(a);
    if (x >= 16 && x % 4 == 0) return x - 16;
    return x;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (m_busy > 0) m_busy--;
    end
  endtask

  task automatic wait_idle();
    idle_cyc(m_busy);
    chk("idle", {31'd0, busy}, 0);
  endtask

  // One-cycle register access, applied to the model as a
  // whole transaction.
  task automatic strobe(input logic [2:0] r,
                        input logic rw,
                        input logic [7:0] d);
    int  nb;
    logic pal;
    cpu_cs  = 1'b1;
    cpu_reg = r;
    cpu_rw  = rw;
    cpu_din = d;
    m_palwr = 1'b0;
    nb = (m_busy > 0) ? m_busy - 1 : 0;
    if (r == 3'd6 && !rw) begin
      if (!m_w) begin
        m_t[13:8] = d[5:0];
        m_w = 1'b1;
      end else begin
        m_t[7:0] = d;
        m_v = m_t;
        m_w = 1'b0;
      end
    end
    if (r == 3'd2 && rw) m_w = 1'b0;
    if (r == 3'd7 && m_busy == 0) begin
      pal = m_v[13:8] == 6'h3F;
      if (rw) begin
        if (pal) begin
          m_dout = ref_pal[ref_idx(m_v[4:0])];
          m_buf  = ref_vram[m_v & 14'h2FFF];
        end else begin
          m_dout = m_buf;
          m_buf  = ref_vram[m_v];
        end
        nb = 2;
      end else if (pal) begin
        if (!render_active) begin
          ref_pal[ref_idx(m_v[4:0])] = d;
          m_palwr = 1'b1;
        end
      end else begin
        ref_vram[m_v] = d;
        nb = 1;
      end
      m_v = 14'((int'(m_v) + (vram_inc32 ? 32 : 1)) % 16384);
    end
    @(negedge clk);
    cpu_cs = 1'b0;
    m_busy = nb;
    chk("dout", {24'd0, cpu_dout}, {24'd0, m_dout});
    chk("busy", {31'd0, busy}, {31'd0, m_busy != 0});
  endtask

  task automatic set_v(input logic [13:0] a);
    if (m_w) strobe(3'd2, 1'b1, 8'h00);
    strobe(3'd6, 1'b0, {2'b00, a[13:8]});
    strobe(3'd6, 1'b0, a[7:0]);
  endtask

  task automatic chk_v(input string tag);
    chk(tag, {18'd0, vram_addr}, {18'd0, m_v});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, op, bad;
    logic [7:0] d;

    for (int i = 0; i < 16384; i++) begin
      d = 8'($urandom);
      vram_mem[i] = d;
      ref_vram[i] = d;
    end
    for (int i = 0; i < 32; i++) begin
      d = 8'($urandom);
      pal_mem[i] = d;
      ref_pal[i] = d;
    end
    m_v = 0; m_t = 0; m_w = 0; m_buf = 0; m_dout = 0;
    m_busy = 0; m_palwr = 0;

    reset_n = 1'b0;
    cpu_cs = 0; cpu_rw = 0; cpu_reg = 0; cpu_din = 0;
    vram_inc32 = 0; render_active = 0; render_pal_idx = 0;
    repeat (3) @(negedge clk);
    chk("rst_dout", {24'd0, cpu_dout}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_we", {29'd0, vram_we, vram_re, pal_we}, 0);
    chk("rst_addr", {18'd0, vram_addr}, 0);
    chk("rst_wdata", {24'd0, vram_wdata}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Palette write through a mirrored index.
    strobe(3'd6, 1'b0, 8'h3F);
    strobe(3'd6, 1'b0, 8'h14);
    strobe(3'd7, 1'b0, 8'h30);
    chk("palwe_hi", {31'd0, pal_we}, 1);
    chk("paladdr", {27'd0, pal_addr}, 32'h04);
    chk("paldin", {24'd0, pal_data_in}, 32'h30);
    idle_cyc(1);
    chk("palwe_lo", {31'd0, pal_we}, 0);
    chk_v("v_3f15");
    chk("v_3f15_k", {18'd0, m_v}, 32'h3F15);

    // Buffered read.
    vram_mem[14'h2000] = 8'hAB; ref_vram[14'h2000] = 8'hAB;
    vram_mem[14'h2001] = 8'hCD; ref_vram[14'h2001] = 8'hCD;
    set_v(14'h2000);
    strobe(3'd7, 1'b1, 8'h00);
    chk("buf_first", {24'd0, cpu_dout}, 32'h00);
    wait_idle();
    strobe(3'd7, 1'b1, 8'h00);
    chk("buf_second", {24'd0, cpu_dout}, 32'hAB);
    wait_idle();
    chk_v("v_2002");

    // Palette read bypasses the buffer but refills it.
    pal_mem[1] = 8'h29; ref_pal[1] = 8'h29;
    vram_mem[14'h2F01] = 8'h55; ref_vram[14'h2F01] = 8'h55;
    set_v(14'h3F01);
    strobe(3'd7, 1'b1, 8'h00);
    chk("pal_rd", {24'd0, cpu_dout}, 32'h29);
    wait_idle();
    set_v(14'h2000);
    strobe(3'd7, 1'b1, 8'h00);
    chk("pal_buf", {24'd0, cpu_dout}, 32'h55);
    wait_idle();

    // $2002 clears the write toggle.
    strobe(3'd6, 1'b0, 8'h21);
    strobe(3'd2, 1'b1, 8'h00);
    strobe(3'd6, 1'b0, 8'h24);
    strobe(3'd6, 1'b0, 8'h00);
    chk_v("v_2400");

    // Wrap-around in both increment modes.
    vram_inc32 = 1;
    set_v(14'h3FF0);
    strobe(3'd7, 1'b0, 8'h11);
    idle_cyc(1);
    chk_v("wrap32");
    vram_inc32 = 0;
    set_v(14'h3FFF);
    strobe(3'd7, 1'b0, 8'h12);
    idle_cyc(1);
    chk_v("wrap1");

    // $2007 while busy is dropped.
    strobe(3'd7, 1'b0, 8'h5A);
    strobe(3'd7, 1'b0, 8'hA5);
    wait_idle();
    chk_v("busy_drop");
    chk("drop_mem", {24'd0, vram_mem[14'h0000]}, 32'h5A);

    // Renderer owns the palette port.
    render_active = 1;
    render_pal_idx = 5'h0B;
    set_v(14'h3F05);
    strobe(3'd7, 1'b0, 8'h77);
    chk("rnd_we", {31'd0, pal_we}, 0);
    chk("rnd_addr", {27'd0, pal_addr}, 32'h0B);
    render_active = 0;
    idle_cyc(1);
    chk_v("rnd_v");

    // Random register traffic.
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      vram_inc32 = ($urandom_range(0, 3) == 0);
      render_active = 0;
      render_pal_idx = 5'($urandom);
      case (op)
        0, 1: begin
          d = (!m_w && $urandom_range(0, 2) == 0)
            ? 8'h3F : 8'($urandom);
          strobe(3'd6, 1'b0, d);
        end
        2: strobe(3'd2, 1'b1, 8'h00);
        3, 4: begin
          render_active = ($urandom_range(0, 3) == 0);
          strobe(3'd7, 1'b0, 8'($urandom));
        end
        5, 6: strobe(3'd7, 1'b1, 8'h00);
        7: if (m_busy == 0 && m_v[13:8] != 6'h3F) begin
          strobe(3'd7, 1'($urandom), 8'($urandom));
          strobe(3'd7, 1'($urandom), 8'($urandom));
        end
        8: strobe(3'd0, 1'b0, 8'($urandom));
        default: wait_idle();
      endcase
      render_active = 0;
      gap = $urandom_range(0, 2);
      if (m_palwr && gap == 0) gap = 1;
      idle_cyc(gap);
      if (m_busy == 0) chk_v("rnd_v_track");
    end
    wait_idle();

    // Asynchronous reset in the middle of a fetch.
    set_v(14'h2000);
    strobe(3'd7, 1'b1, 8'h00);
    chk("fetch_re", {31'd0, vram_re}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_re", {31'd0, vram_re}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    m_v = 0; m_t = 0; m_w = 0; m_buf = 0; m_dout = 0;
    m_busy = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_dout", {24'd0, cpu_dout}, 0);
    chk_v("arst_v");

    bad = 0;
    for (int i = 0; i < 16384; i++)
      if (vram_mem[i] !== ref_vram[i]) bad++;
    chk("vram_image", bad, 0);
    for (int i = 0; i < 32; i++)
      chk("pal_image", {24'd0, pal_mem[i]},
          {24'd0, ref_pal[i]});

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
